// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: writeback-to-chip-output pipeline stage.
// Valid/ready handshake with a two-entry (main + skid) buffer. in_ready is
// driven straight from a state flop, so out_ready never reaches it
// combinationally. flush drops all held beats but leaves data registers alone.
// Optional macro WB_STAGE_PERF_EN adds saturating stall/bubble counters.
module wb_pipe_stage #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 30
`ifdef WB_STAGE_PERF_EN
  ,
  parameter int CNT_WIDTH   = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]    in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc
`ifdef WB_STAGE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]   stall_count,
  output logic [CNT_WIDTH-1:0]   bubble_count
`endif
);

  // State bits are {main_valid, skid_valid}, so the valid flags are state bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic                   accept, take;
  logic                   main_ld_in, skid_ld_in, main_ld_skid;
  logic [INSTR_WIDTH-1:0] main_instr_q, skid_instr_q;
  logic [PC_WIDTH-1:0]    main_pc_q, skid_pc_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state and register-load decode; flush overrides every transition
  always_comb begin
    state_d      = state_q;
    main_ld_in   = 1'b0;
    skid_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    accept       = in_valid & ~state_q[0] & ~flush;
    take         = state_q[1] & out_ready;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ld_in = 1'b1;
            state_d    = BUSY;
          end
        end
        BUSY: begin
          case ({accept, take})
            2'b11: main_ld_in = 1'b1;
            2'b10: begin
              skid_ld_in = 1'b1;
              state_d    = FULL;
            end
            2'b01: state_d = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (take) begin
            main_ld_skid = 1'b1;
            state_d      = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs come straight from flops
  always_comb begin
    out_valid = state_q[1];
    in_ready  = ~state_q[0];
    out_instr = main_instr_q;
    out_pc    = main_pc_q;
  end

  // Main and skid data registers; only loaded, never cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      if (main_ld_in) begin
        main_instr_q <= in_instr;
        main_pc_q    <= in_pc;
      end else if (main_ld_skid) begin
        main_instr_q <= skid_instr_q;
        main_pc_q    <= skid_pc_q;
      end
      if (skid_ld_in) begin
        skid_instr_q <= in_instr;
        skid_pc_q    <= in_pc;
      end
    end
  end

`ifdef WB_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, bubble_q;

  // Saturating counters keyed on the pre-edge out_valid; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (state_q[1] && !out_ready && stall_q != '1)
        stall_q <= stall_q + CNT_WIDTH'(1);
      if (!state_q[1] && bubble_q != '1)
        bubble_q <= bubble_q + CNT_WIDTH'(1);
    end
  end

  // Counter outputs
  always_comb begin
    stall_count  = stall_q;
    bubble_count = bubble_q;
  end
`endif

endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

Parametrised writeback pipeline stage with a valid/ready handshake and a two-entry skid buffer, carrying instruction and program counter from the writeback stage to the chip-level outputs. Replaces the unconditional per-cycle register with a stage that can stall, absorb one beat of back-pressure without a combinational ready path, and be flushed. Sits between the writeback stage and the chip output boundary.

## Interface
Parameters:
- INSTR_WIDTH, 32, instruction word width in bits
- PC_WIDTH, 30, program counter width in bits (word-addressed, INSTR_WIDTH-2)
- CNT_WIDTH, 16, width of the performance counters (only with WB_STAGE_PERF_EN)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous flush; drops all held entries
- in_valid  input  1  upstream has a beat on in_instr/in_pc
- in_ready  output  1  stage can accept a beat this cycle; registered
- in_instr  input  INSTR_WIDTH  incoming instruction
- in_pc  input  PC_WIDTH  incoming program counter
- out_valid  output  1  out_instr/out_pc hold a valid beat
- out_ready  input  1  downstream consumes the beat this cycle
- out_instr  output  INSTR_WIDTH  outgoing instruction; registered
- out_pc  output  PC_WIDTH  outgoing program counter; registered
- stall_count  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0 (only with WB_STAGE_PERF_EN)
- bubble_count  output  CNT_WIDTH  cycles with out_valid=0 (only with WB_STAGE_PERF_EN)

## Operation
- Storage: main register (drives out_*) and skid register, each with a valid bit.
- Accept = in_valid & in_ready. Take = out_valid & out_ready.
- States, encoded by the valid bits:
  - EMPTY (main invalid, skid invalid): accept -> main<=in, BUSY; otherwise stay.
  - BUSY (main valid, skid invalid): accept&take -> main<=in, stay BUSY; accept&!take -> skid<=in, FULL; !accept&take -> EMPTY; neither -> stay.
  - FULL (main valid, skid valid): take -> main<=skid, skid invalid, BUSY; otherwise stay. No accept is possible because in_ready=0.
- in_ready = !skid_valid, taken directly from a flop. There is no combinational path from out_ready to in_ready.
- out_valid = main valid bit. out_instr/out_pc = main data.
- Ordering: strict FIFO. Beats leave in arrival order, and none is duplicated or lost except on flush.
- flush has the highest priority. On the next edge both valid bits clear and the state becomes EMPTY. Any beat offered in the flush cycle is dropped, even if in_ready=1. Data registers keep their values and only valid clears.
- Reset (rst_n=0, asynchronous): both valid bits 0, data registers 0. Outputs during and after reset: out_valid=0, out_instr=0, out_pc=0, in_ready=1, counters 0.
- Reset deasserted mid-transfer: all in-flight beats are lost. The stage is in EMPTY on the first edge after release.

## Timing
- Latency: a beat accepted at edge N appears on out_* at N (out_valid high in cycle N+1 when the stage was EMPTY or BUSY with a take).
- Throughput: one beat per cycle while out_ready=1 is held.
- Back-pressure: in_ready falls one cycle after the first un-taken accept in BUSY. It rises one cycle after the take in FULL.
- While out_valid=1 and out_ready=0, out_instr/out_pc stay stable. out_valid never drops without a take or a flush.
- Data widths are pass-through. No arithmetic is applied to the PC.

## Configuration
- WB_STAGE_PERF_EN defined:
  - stall_count and bubble_count ports and counters exist.
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones.
  - Both counters clear only on reset. flush does not clear them.
  - A flush cycle counts by the pre-flush out_valid.
- WB_STAGE_PERF_EN undefined: ports and counters are absent. The datapath is otherwise identical.

## Test plan
- Streaming: in_valid=1, out_ready=1, pc 0x10..0x17 -> out_pc 0x10..0x17 one per cycle from the cycle after the first accept, in_ready stays 1.
- Back-pressure: push 0xA,0xB with out_ready=0 -> state FULL, in_ready=0; hold 5 cycles with out_pc=0xA stable; raise out_ready -> 0xA then 0xB, in_ready=1 one cycle after the first take.
- Flush while FULL with in_valid=1 pc=0xC -> next cycle out_valid=0, in_ready=1, 0xC never appears at the output.
- Asynchronous reset asserted mid-stream between edges -> out_valid=0, out_instr=0, out_pc=0, in_ready=1 immediately; first beat after release emerges with 1-cycle latency.
- With WB_STAGE_PERF_EN and CNT_WIDTH=4: 20 stalled cycles -> stall_count=15 (saturated); 3 idle cycles after reset -> bubble_count=3.
